// File: rtl/data_uncache_resp.sv
// Uncached data-side responder: one request in flight, serves MMIO loads/stores
// over a simple rd/wr bus and returns a single-cycle data_ok with the raw word.
module data_uncache_resp #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_req,
   input  logic                 data_wr,
   input  logic [1:0]           data_size,
   input  logic [DATA_WD/8-1:0] data_wstrb,
   input  logic [ADDR_WD-1:0]   data_addr,
   input  logic [DATA_WD-1:0]   data_wdata,
   output logic                 data_addr_ok,
   output logic                 data_data_ok,
   output logic [DATA_WD-1:0]   data_rdata,
   input  logic                 data_uncache_en,
   input  logic                 tlb_excp_cancel_req,
   input  logic                 flush,
   output logic                 rd_req,
   input  logic                 rd_rdy,
   output logic [ADDR_WD-1:0]   rd_addr,
   output logic [1:0]           rd_size,
   input  logic                 ret_valid,
   input  logic [DATA_WD-1:0]   ret_data,
   output logic                 wr_req,
   input  logic                 wr_rdy,
   output logic [ADDR_WD-1:0]   wr_addr,
   output logic [1:0]           wr_size,
   output logic [DATA_WD/8-1:0] wr_wstrb,
   output logic [DATA_WD-1:0]   wr_data,
   output logic                 uncache_busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      WR_REQ  = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_kill;
   logic                  w_kill_nxt;
   logic                  r_wr;
   logic [1:0]            r_size;
   logic [DATA_WD/8-1:0]  r_wstrb;
   logic [ADDR_WD-1:0]    r_addr;
   logic [DATA_WD-1:0]    r_wdata;
   logic [DATA_WD-1:0]    r_rdata;
   logic                  w_accept;
   logic                  w_load_ret;

   assign w_accept = (r_state == IDLE) & data_req & ~flush & reset;

   always_comb begin
      w_next     = r_state;
      w_kill_nxt = r_kill;
      unique case (r_state)
         IDLE: begin
            w_kill_nxt = 1'b0;
            if (w_accept) w_next = LOOKUP;
         end
         LOOKUP: begin
            if (flush | tlb_excp_cancel_req | ~data_uncache_en)
               w_next = IDLE;
            else if (r_wr)
               w_next = WR_REQ;
            else
               w_next = RD_REQ;
         end
         RD_REQ: begin
            // a flush coinciding with the handshake still owes us a beat
            if (rd_rdy) begin
               w_next     = RD_WAIT;
               w_kill_nxt = flush;
            end else if (flush) begin
               w_next = IDLE;
            end
         end
         RD_WAIT: begin
            w_kill_nxt = r_kill | flush;
            if (ret_valid) w_next = w_kill_nxt ? IDLE : RESP;
         end
         WR_REQ: begin
            if (wr_rdy)
               w_next = flush ? IDLE : RESP;
            else if (flush)
               w_next = IDLE;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_load_ret = (r_state == RD_WAIT) & ret_valid & ~w_kill_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_kill  <= 1'b0;
         r_wr    <= 1'b0;
         r_size  <= '0;
         r_wstrb <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_kill  <= w_kill_nxt;
         if (w_accept) begin
            r_wr    <= data_wr;
            r_size  <= data_size;
            r_wstrb <= data_wstrb;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
         end
         if (w_load_ret) r_rdata <= ret_data;
      end
   end

   assign data_addr_ok = w_accept;
   assign data_data_ok = (r_state == RESP) & ~flush;
   assign data_rdata   = r_rdata;
   assign rd_req       = (r_state == RD_REQ);
   assign rd_addr      = r_addr;
   assign rd_size      = r_size;
   assign wr_req       = (r_state == WR_REQ);
   assign wr_addr      = r_addr;
   assign wr_size      = r_size;
   assign wr_wstrb     = r_wstrb;
   assign wr_data      = r_wdata;
   assign uncache_busy = (r_state != IDLE);

endmodule
